// File: rtl/calc_pkg.sv
// Shared calculator definitions: default widths, converter FSM states
// and seven-segment glyph constants used by the display path.
package calc_pkg;

    localparam int IN_W_DEF   = 10;
    localparam int DIGITS_DEF = 4;
    localparam int BCD_W      = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is >= 5.
// Ports: din (4-bit nibble in), dout (corrected nibble out).
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed-BCD converter, IN_W cycles.
// Ports: CLOCK_50, RESET (async high), start, bin_in, neg_in in;
//        busy, done (pulse), bcd_out, neg_out, ovf out (held until next done).
module bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [IN_W-1:0]           bin_in,
    input  logic                      neg_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      neg_out,
    output logic                      ovf
);

    localparam int BCD_BITS = BCD_W * DIGITS;
    localparam int SR_W     = BCD_BITS + IN_W;
    localparam int CNT_W    = $clog2(IN_W + 1);
    localparam longint unsigned LIMIT = 64'(10) ** DIGITS;

    conv_state_t       state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_next;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;
    logic              ovf_q;
    logic              ovf_next;
    logic              last;

    // Digit corrections act on the BCD field only; binary field passes through.
    assign sr_adj[IN_W-1:0] = sr[IN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .din  (sr[IN_W + g*BCD_W +: BCD_W]),
            .dout (sr_adj[IN_W + g*BCD_W +: BCD_W])
        );
    end

    assign sr_next  = {sr_adj[SR_W-2:0], 1'b0};
    assign last     = (cnt == CNT_W'(IN_W - 1));
    assign ovf_next = (64'(bin_in) >= LIMIT);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            sr      <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            neg_out <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr    <= {{BCD_BITS{1'b0}}, bin_in};
                        cnt   <= '0;
                        // No "-0": sign dropped for a zero magnitude.
                        neg_q <= neg_in & (bin_in != '0);
                        ovf_q <= ovf_next;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // Result taken from the final shift directly.
                        bcd_out <= sr_next[SR_W-1:IN_W];
                        neg_out <= neg_q;
                        ovf     <= ovf_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Covers default (4-digit) and 2-digit builds.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;

    logic        start4, neg4;
    logic [9:0]  bin4;
    logic        busy4, done4, nego4, ovf4;
    logic [15:0] bcd4;

    logic        start2, neg2;
    logic [9:0]  bin2;
    logic        busy2, done2, nego2, ovf2;
    logic [7:0]  bcd2;

    int applied;
    int miscompares;

    bin_to_bcd_seq u4 (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .start    (start4),
        .bin_in   (bin4),
        .neg_in   (neg4),
        .busy     (busy4),
        .done     (done4),
        .bcd_out  (bcd4),
        .neg_out  (nego4),
        .ovf      (ovf4)
    );

    bin_to_bcd_seq #(.IN_W(10), .DIGITS(2)) u2 (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .start    (start2),
        .bin_in   (bin2),
        .neg_in   (neg2),
        .busy     (busy2),
        .done     (done2),
        .bcd_out  (bcd2),
        .neg_out  (nego2),
        .ovf      (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start on one DUT, waits (bounded) for done and returns
    // latency from accept edge, busy cycle count and the result.
    task automatic run_conv(input bit d2, input logic [9:0] b,
                            input logic n, output int lat,
                            output int busyc, output logic [15:0] bcd,
                            output logic ng, output logic ov);
        if (d2) begin start2 = 1'b1; bin2 = b; neg2 = n; end
        else    begin start4 = 1'b1; bin4 = b; neg4 = n; end
        @(posedge clk); #1;
        start4 = 1'b0;
        start2 = 1'b0;
        busyc = (d2 ? busy2 : busy4) ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (d2 ? done2 : done4) begin
                lat = i;
                break;
            end
            if (d2 ? busy2 : busy4) busyc++;
        end
        bcd = d2 ? {8'h00, bcd2} : bcd4;
        ng  = d2 ? nego2 : nego4;
        ov  = d2 ? ovf2 : ovf4;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        applied++;
        if ({busy4, done4, nego4, ovf4, bcd4} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset4: got busy=%b done=%b neg=%b ovf=%b bcd=%h want all 0",
                     busy4, done4, nego4, ovf4, bcd4);
        end
        applied++;
        if ({busy2, done2, nego2, ovf2, bcd2} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset2: got busy=%b done=%b bcd=%h want all 0",
                     busy2, done2, bcd2);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat, bc;
        logic [15:0] bcd;
        logic ng, ov;
        run_conv(1'b0, 10'd0, 1'b0, lat, bc, bcd, ng, ov);
        applied++;
        if (lat !== 10) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d want 10", lat);
        end
        applied++;
        if (bc !== 10) begin
            miscompares++;
            $display("FAIL zero_busy_cycles: got %0d want 10", bc);
        end
        applied++;
        if ({bcd, ov, ng} !== 18'h0) begin
            miscompares++;
            $display("FAIL zero_result: got bcd=%h ovf=%b neg=%b want 0000/0/0",
                     bcd, ov, ng);
        end
        applied++;
        if (busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_busy_in_done: got %b want 0", busy4);
        end
        @(posedge clk); #1;
        applied++;
        if (done4 !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got %b want 0", done4);
        end
    endtask

    task automatic test_values;
        logic [9:0]  vin [3];
        logic [15:0] vexp [3];
        int lat, bc;
        logic [15:0] bcd;
        logic ng, ov;
        vin[0] = 10'd1023; vexp[0] = 16'h1023;
        vin[1] = 10'd961;  vexp[1] = 16'h0961;
        vin[2] = 10'd62;   vexp[2] = 16'h0062;
        for (int i = 0; i < 3; i++) begin
            run_conv(1'b0, vin[i], 1'b0, lat, bc, bcd, ng, ov);
            applied++;
            if (lat !== 10 || bcd !== vexp[i] || ov !== 1'b0 || ng !== 1'b0) begin
                miscompares++;
                $display("FAIL value_%0d: got lat=%0d bcd=%h ovf=%b neg=%b want 10/%h/0/0",
                         vin[i], lat, bcd, ov, ng, vexp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sign;
        int lat, bc;
        logic [15:0] bcd;
        logic ng, ov;
        run_conv(1'b0, 10'd26, 1'b1, lat, bc, bcd, ng, ov);
        applied++;
        if (bcd !== 16'h0026 || ng !== 1'b1) begin
            miscompares++;
            $display("FAIL neg_26: got bcd=%h neg=%b want 0026/1", bcd, ng);
        end
        @(posedge clk); #1;
        run_conv(1'b0, 10'd0, 1'b1, lat, bc, bcd, ng, ov);
        applied++;
        if (bcd !== 16'h0000 || ng !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_zero: got bcd=%h neg=%b want 0000/0", bcd, ng);
        end
    endtask

    task automatic test_ignore_start;
        int ndone;
        logic [15:0] got;
        @(posedge clk); #1;
        start4 = 1'b1; bin4 = 10'd999; neg4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        ndone = 0;
        got = 16'hxxxx;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                ndone++;
                got = bcd4;
            end
            start4 = (i == 3 || i == 7);
            bin4 = 10'd5;
        end
        start4 = 1'b0;
        applied++;
        if (ndone !== 1) begin
            miscompares++;
            $display("FAIL ignore_start_count: got %0d dones want 1", ndone);
        end
        applied++;
        if (got !== 16'h0999) begin
            miscompares++;
            $display("FAIL ignore_start_value: got %h want 0999", got);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc, wait1;
        logic [15:0] bcd;
        logic ng, ov;
        start4 = 1'b1; bin4 = 10'd999; neg4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait1 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                wait1 = i;
                break;
            end
        end
        applied++;
        if (wait1 !== 10 || bcd4 !== 16'h0999) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d bcd=%h want 10/0999", wait1, bcd4);
        end
        run_conv(1'b0, 10'd5, 1'b0, lat, bc, bcd, ng, ov);
        applied++;
        if (lat !== 10 || bcd !== 16'h0005) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d bcd=%h want 10/0005", lat, bcd);
        end
    endtask

    task automatic test_reset_mid;
        int ndone, lat, bc;
        logic [15:0] bcd;
        logic ng, ov;
        @(posedge clk); #1;
        start4 = 1'b1; bin4 = 10'd500; neg4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        applied++;
        if ({busy4, done4, nego4, ovf4, bcd4} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy=%b bcd=%h neg=%b want 0/0000/0",
                     busy4, bcd4, nego4);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done4 || busy4) ndone++;
        end
        applied++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d active cycles want 0", ndone);
        end
        run_conv(1'b0, 10'd77, 1'b0, lat, bc, bcd, ng, ov);
        applied++;
        if (lat !== 10 || bcd !== 16'h0077) begin
            miscompares++;
            $display("FAIL after_reset_77: got lat=%0d bcd=%h want 10/0077", lat, bcd);
        end
    endtask

    task automatic test_digits2;
        int lat, bc;
        logic [15:0] bcd;
        logic ng, ov;
        run_conv(1'b1, 10'd123, 1'b0, lat, bc, bcd, ng, ov);
        applied++;
        if (lat !== 10 || ov !== 1'b1 || bcd !== 16'h0023) begin
            miscompares++;
            $display("FAIL d2_123: got lat=%0d ovf=%b bcd=%h want 10/1/23", lat, ov, bcd);
        end
        @(posedge clk); #1;
        run_conv(1'b1, 10'd99, 1'b0, lat, bc, bcd, ng, ov);
        applied++;
        if (lat !== 10 || ov !== 1'b0 || bcd !== 16'h0099) begin
            miscompares++;
            $display("FAIL d2_99: got lat=%0d ovf=%b bcd=%h want 10/0/99", lat, ov, bcd);
        end
        @(posedge clk); #1;
        run_conv(1'b1, 10'd100, 1'b0, lat, bc, bcd, ng, ov);
        applied++;
        if (ov !== 1'b1 || bcd !== 16'h0000) begin
            miscompares++;
            $display("FAIL d2_100: got ovf=%b bcd=%h want 1/00", ov, bcd);
        end
    endtask

    initial begin
        applied = 0;
        miscompares = 0;
        rst = 1'b1;
        start4 = 1'b0; bin4 = '0; neg4 = 1'b0;
        start2 = 1'b0; bin2 = '0; neg2 = 1'b0;
        #1;
        test_reset;
        test_zero;
        test_values;
        test_sign;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_digits2;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
